// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronised rx, mid-bit sampling, ready/error strobes.
// Define UART_RX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_rx #(
    parameter int CLKS_PER_BIT = 1042
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] Rx_byte,
    output logic       ready,
    output logic       busy,
    output logic       framing_err,
    output logic       parity_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t        state, state_nxt;
    logic          rx_meta, rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          cnt_done, half_done;
    logic          ready_nxt, framing_nxt, parity_nxt;
    logic          par_bad;

    assign cnt_done  = (cnt == CNT_MAX);
    assign half_done = (cnt == CNT_HALF);

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= parity_nxt;
            if (state == PARITY && cnt_done)
                par_bad <= (^shreg) ^ rx_s;
        end
    end
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            Rx_byte     <= '0;
            ready       <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            rx_meta     <= rx;
            rx_s        <= rx_meta;
            ready       <= ready_nxt;
            framing_err <= framing_nxt;
            if (ready_nxt)
                Rx_byte <= shreg;
            case (state)
                START: begin
                    cnt     <= half_done ? '0 : cnt + 1'b1;
                    bit_idx <= '0;
                end
                DATA: begin
                    cnt <= cnt_done ? '0 : cnt + 1'b1;
                    if (cnt_done) begin
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: cnt <= cnt_done ? '0 : cnt + 1'b1;
`endif
                STOP:    cnt <= cnt_done ? '0 : cnt + 1'b1;
                default: cnt <= '0;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!rx_s) state_nxt = START;
            START: if (half_done) state_nxt = rx_s ? IDLE : DATA;
            DATA: begin
                if (cnt_done && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (cnt_done) state_nxt = STOP;
`endif
            STOP:    if (cnt_done) state_nxt = rx_s ? IDLE : BREAK;
            BREAK:   if (rx_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are decided at mid stop bit; a low stop bit overrides parity.
    always_comb begin
        busy        = (state != IDLE);
        ready_nxt   = 1'b0;
        framing_nxt = 1'b0;
        parity_nxt  = 1'b0;
        if (state == STOP && cnt_done) begin
            framing_nxt = !rx_s;
            parity_nxt  = rx_s && par_bad;
            ready_nxt   = rx_s && !par_bad;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed steps plus randomized frames
// compared against a frame-level expectation model.
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int FRAME_BITS = PAR_EN ? 11 : 10;
    localparam int EXP_LAT    = 2 + CPB / 2 + (FRAME_BITS - 1) * CPB;

    logic       tb_clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] Rx_byte;
    logic       ready, busy, framing_err, parity_err;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(tb_clk), .rst(rst), .rx(rx), .Rx_byte(Rx_byte), .ready(ready),
        .busy(busy), .framing_err(framing_err), .parity_err(parity_err)
    );

    always #5 tb_clk = ~tb_clk;

    int cyc = 0;
    always @(posedge tb_clk) cyc <= cyc + 1;

    int         ready_cnt = 0, fe_cnt = 0, pe_cnt = 0, busy_cnt = 0;
    int         overlap_cnt = 0, long_cnt = 0, last_ready_cyc = 0;
    logic       prev_r = 1'b0, prev_f = 1'b0, prev_p = 1'b0;
    logic [7:0] got[$];

    always @(negedge tb_clk) begin
        if (ready) begin
            ready_cnt++;
            last_ready_cyc = cyc;
            got.push_back(Rx_byte);
        end
        if (framing_err) fe_cnt++;
        if (parity_err)  pe_cnt++;
        if (busy)        busy_cnt++;
        if (ready && framing_err) overlap_cnt++;
        if ((ready && prev_r) || (framing_err && prev_f) || (parity_err && prev_p)) long_cnt++;
        prev_r = ready;
        prev_f = framing_err;
        prev_p = parity_err;
    end

    int checks = 0, passes = 0, fails = 0;
    int frame_start_cyc = 0;
    int r0, f0, p0, b0, lat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge tb_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_ok);
        frame_start_cyc = cyc;
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(d[i], CPB);
        if (PAR_EN) hold(par_ok ? ^d : ~^d, CPB);
        hold(stop_bit, CPB);
    endtask

    task automatic snap();
        r0 = ready_cnt; f0 = fe_cnt; p0 = pe_cnt; b0 = busy_cnt;
    endtask

    task automatic chk_lat(input string tag);
        lat = last_ready_cyc - frame_start_cyc - 1;
        checks++;
        assert (lat >= EXP_LAT - 2 && lat <= EXP_LAT + 2) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed latency %0d expected %0d +/-2", tag, lat, EXP_LAT);
        end
    endtask

    logic [7:0] d, model_byte;
    logic       stop_ok, par_ok, good;
    int         gap;

    initial begin
        rst = 1'b1;
        rx  = 1'b0;
        @(negedge tb_clk);
        @(negedge tb_clk);
        chk("rst_byte", 32'(Rx_byte), 32'h00);
        chk("rst_strobes", 32'({ready, busy, framing_err, parity_err}), 32'h0);
        rst = 1'b0;
        snap();
        hold(1'b1, 300);
        chk("idle_byte", 32'(Rx_byte), 32'h00);
        chk("idle_ready", 32'(ready_cnt - r0), 0);
        chk("idle_busy", 32'(busy_cnt - b0), 0);
        chk("idle_errs", 32'((fe_cnt - f0) + (pe_cnt - p0)), 0);

        snap();
        send_frame(8'h35, 1'b1, 1'b1);
        chk("f35_ready", 32'(ready_cnt - r0), 1);
        chk("f35_byte", 32'(Rx_byte), 32'h35);
        chk_lat("f35_lat");
        chk("f35_busy_after", 32'(busy), 0);

        snap();
        hold(1'b0, 4);
        hold(1'b1, 40);
        chk("glitch_busy_seen", 32'(busy_cnt - b0 > 0), 1);
        chk("glitch_busy_now", 32'(busy), 0);
        chk("glitch_strobes", 32'((ready_cnt - r0) + (fe_cnt - f0)), 0);
        chk("glitch_byte", 32'(Rx_byte), 32'h35);

        snap();
        send_frame(8'hA5, 1'b0, 1'b1);
        hold(1'b0, 40);
        chk("brk_fe", 32'(fe_cnt - f0), 1);
        chk("brk_no_ready", 32'(ready_cnt - r0), 0);
        chk("brk_byte", 32'(Rx_byte), 32'h35);
        chk("brk_busy", 32'(busy), 1);
        hold(1'b1, 20);
        chk("brk_fe_single", 32'(fe_cnt - f0), 1);
        send_frame(8'h0F, 1'b1, 1'b1);
        chk("f0f_ready", 32'(ready_cnt - r0), 1);
        chk("f0f_byte", 32'(Rx_byte), 32'h0F);

        snap();
        send_frame(8'h41, 1'b1, 1'b1);
        send_frame(8'h42, 1'b1, 1'b1);
        hold(1'b1, 4);
        chk("b2b_count", 32'(ready_cnt - r0), 2);
        chk("b2b_first", 32'(got[got.size() - 2]), 32'h41);
        chk("b2b_second", 32'(got[got.size() - 1]), 32'h42);

        snap();
        hold(1'b0, CPB);
        for (int i = 0; i < 3; i++) hold(1'b1 ^ i[0], CPB);
        rst = 1'b1;
        hold(1'b1, 2);
        rst = 1'b0;
        hold(1'b1, 20);
        chk("mid_rst_strobes", 32'((ready_cnt - r0) + (fe_cnt - f0) + (pe_cnt - p0)), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        send_frame(8'h7E, 1'b1, 1'b1);
        chk("f7e_ready", 32'(ready_cnt - r0), 1);
        chk("f7e_byte", 32'(Rx_byte), 32'h7E);
        chk_lat("f7e_lat");
        model_byte = 8'h7E;

`ifdef UART_RX_PARITY_EN
        snap();
        send_frame(8'h03, 1'b1, 1'b0);
        chk("par_bad_pe", 32'(pe_cnt - p0), 1);
        chk("par_bad_ready", 32'(ready_cnt - r0), 0);
        chk("par_bad_byte", 32'(Rx_byte), 32'h7E);
        send_frame(8'h03, 1'b1, 1'b1);
        chk("par_ok_ready", 32'(ready_cnt - r0), 1);
        chk("par_ok_byte", 32'(Rx_byte), 32'h03);
        chk("par_ok_pe", 32'(pe_cnt - p0), 1);
        model_byte = 8'h03;
`endif

        for (int n = 0; n < 24; n++) begin
            d       = 8'($urandom_range(0, 255));
            stop_ok = ($urandom_range(0, 4) != 0);
            par_ok  = ($urandom_range(0, 3) != 0);
            gap     = $urandom_range(0, 12);
            good    = stop_ok && (par_ok || !PAR_EN);
            snap();
            send_frame(d, stop_ok, par_ok);
            if (!stop_ok) begin
                hold(1'b0, 40);
                hold(1'b1, 4);
            end
            if (good) model_byte = d;
            chk("rnd_ready", 32'(ready_cnt - r0), 32'(good));
            chk("rnd_fe", 32'(fe_cnt - f0), 32'(!stop_ok));
            chk("rnd_pe", 32'(pe_cnt - p0), 32'(stop_ok && !par_ok && PAR_EN));
            chk("rnd_byte", 32'(Rx_byte), 32'(model_byte));
            if (good) chk_lat("rnd_lat");
            hold(1'b1, gap);
        end

        hold(1'b1, 20);
        chk("no_ready_fe_overlap", 32'(overlap_cnt), 0);
        chk("no_long_strobe", 32'(long_cnt), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
